radix4_booth_arbiter: RTL and testbench

//  Shares one radix-4 Booth multiplier among NUM_REQ requesters using round-robin arbitration.

---
 rtl/radix4_booth_arbiter.sv | 106 ++++++++++
 tb/tb_radix4_booth_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/radix4_booth_arbiter.sv
// radix4_booth_arbiter: round-robin front end sharing one radix-4 Booth multiplier among requesters
module radix4_booth_arbiter #(
    parameter int WIDTH          = 8,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_b,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] o_rsp_id,
    output logic [2*WIDTH-1:0]         o_rsp_product,
    output logic                       o_rsp_err,
    output logic                       o_mul_en,
    output logic                       o_mul_start,
    output logic [WIDTH-1:0]           o_mul_a,
    output logic [WIDTH-1:0]           o_mul_b,
    input  logic                       i_mul_done,
    input  logic [2*WIDTH-1:0]         i_mul_product
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE_S, ISSUE_S, CLR_S, WAIT_S, RESP_S} state_t;

    state_t             r_state, w_next;
    logic [IDW-1:0]     r_rr_ptr, w_gnt, r_rsp_id;
    logic [TW-1:0]      r_tmo_cnt;
    logic [WIDTH-1:0]   r_mul_a, r_mul_b;
    logic [2*WIDTH-1:0] r_rsp_product;
    logic               r_rsp_valid, r_rsp_err;
    logic               w_found, w_tmo, w_ok, w_busy;

    // Descending scan so the smallest offset from the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (i_req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_gnt   = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_busy = r_state == CLR_S || r_state == WAIT_S;
    assign w_tmo  = TIMEOUT_CYCLES != 0 && int'(r_tmo_cnt) == TIMEOUT_CYCLES - 1;
    assign w_ok   = r_state == WAIT_S && i_mul_done;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE_S:  w_next = w_found ? ISSUE_S : IDLE_S;
            ISSUE_S: w_next = CLR_S;
            CLR_S:   w_next = !i_mul_done ? WAIT_S : (w_tmo ? RESP_S : CLR_S);
            WAIT_S:  w_next = (i_mul_done || w_tmo) ? RESP_S : WAIT_S;
            RESP_S:  w_next = i_rsp_ready ? IDLE_S : RESP_S;
            default: w_next = IDLE_S;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE_S;
            r_rr_ptr      <= IDW'(NUM_REQ - 1);
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_product <= '0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_tmo_cnt     <= '0;
        end else begin
            r_state     <= w_next;
            r_rsp_valid <= w_next == RESP_S;
            if (r_state == IDLE_S && w_found) begin
                r_mul_a  <= i_req_a[int'(w_gnt)*WIDTH +: WIDTH];
                r_mul_b  <= i_req_b[int'(w_gnt)*WIDTH +: WIDTH];
                r_rsp_id <= w_gnt;
                r_rr_ptr <= w_gnt;
            end
            if (r_state == ISSUE_S)
                r_tmo_cnt <= '0;
            else if (w_busy)
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            if (w_busy && w_next == RESP_S) begin
                r_rsp_product <= w_ok ? i_mul_product : '0;
                r_rsp_err     <= !w_ok;
            end
        end
    end

    assign o_req_ready   = (!rst && r_state == IDLE_S && w_found) ? NUM_REQ'(1) << w_gnt : '0;
    assign o_mul_start   = !rst && r_state == ISSUE_S;
    assign o_mul_en      = !rst && (r_state == ISSUE_S || w_busy);
    assign o_mul_a       = r_mul_a;
    assign o_mul_b       = r_mul_b;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_id      = r_rsp_id;
    assign o_rsp_product = r_rsp_product;
    assign o_rsp_err     = r_rsp_err;
endmodule

// File: tb/tb_radix4_booth_arbiter.sv
// tb_radix4_booth_arbiter: directed scoreboard bench with a behavioural multiplier model
module tb_radix4_booth_arbiter;
    localparam int W = 8, N = 4, TMO = 64;

    logic             clk = 0, rst = 1;
    logic [N-1:0]     req_valid = '0, req_ready;
    logic [N*W-1:0]   req_a = '0, req_b = '0;
    logic             rsp_valid, rsp_ready = 1, rsp_err;
    logic [1:0]       rsp_id;
    logic [2*W-1:0]   rsp_product;
    logic             mul_en, mul_start, mul_done = 0;
    logic [W-1:0]     mul_a, mul_b;
    logic [2*W-1:0]   mul_product = '0;

    int checks = 0, failures = 0, cyc = 0, n_gnt = 0, n_rsp = 0, g_cyc = 0;
    int m_lat = 1, m_stale = 0, m_cnt = 0;
    bit m_stuck = 0, exp_err = 0, in_op = 0;

    typedef struct {int id; logic [15:0] p; logic e; int lat;} exp_t;
    exp_t sb[$];
    int   exp_gnt[$];

    logic prev_rv = 0, prev_rr = 0, prev_e = 0;
    logic [1:0]  prev_id = 0;
    logic [15:0] prev_p = 0;

    radix4_booth_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_a(req_a), .i_req_b(req_b),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_id(rsp_id), .o_rsp_product(rsp_product), .o_rsp_err(rsp_err),
        .o_mul_en(mul_en), .o_mul_start(mul_start),
        .o_mul_a(mul_a), .o_mul_b(mul_b),
        .i_mul_done(mul_done), .i_mul_product(mul_product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Multiplier: done optionally stays high m_stale cycles after start, then rises m_lat cycles later.
    always @(posedge clk) begin
        if (mul_start) begin
            m_cnt <= 1;
            if (m_stale == 0) mul_done <= 0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == m_stale) mul_done <= 0;
            if (!m_stuck && m_cnt == m_stale + m_lat) begin
                mul_done    <= 1;
                mul_product <= $signed(mul_a) * $signed(mul_b);
                m_cnt       <= 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        logic signed [W-1:0] a, b;
        if (rst) begin
            prev_rv = 0;
            in_op   = 0;
        end else begin
            chk("ready_legal", {63'd0, $onehot0(req_ready) && (req_ready & ~req_valid) == 0}, 1);
            if (rsp_valid) in_op = 0;
            chk("mul_en", mul_en, in_op);
            if (mul_start) chk("start_lat", cyc - g_cyc, 1);
            if (|(req_ready & req_valid)) begin
                n_gnt++;
                g_cyc = cyc;
                in_op = 1;
                if (exp_gnt.size() == 0) chk("gnt_unexpected", req_ready, 0);
                else begin
                    e.id = exp_gnt.pop_front();
                    chk("gnt_id", req_ready, 1 << e.id);
                    a = req_a[e.id*W +: W];
                    b = req_b[e.id*W +: W];
                    if (exp_err) e.p = 0;
                    else e.p = a * b;
                    e.e   = exp_err;
                    e.lat = m_stuck ? TMO + 2 : 3 + m_stale + m_lat;
                    sb.push_back(e);
                end
            end
            if (rsp_valid && !prev_rv) begin
                if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
                else chk("rsp_lat", cyc - g_cyc, sb[0].lat);
            end
            if (rsp_valid && prev_rv && !prev_rr) begin
                chk("hold_id", rsp_id, prev_id);
                chk("hold_prod", rsp_product, prev_p);
                chk("hold_err", rsp_err, prev_e);
            end
            if (rsp_valid && rsp_ready && sb.size() != 0) begin
                e = sb.pop_front();
                n_rsp++;
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_prod", rsp_product, e.p);
                chk("rsp_err", rsp_err, e.e);
            end
            prev_rv = rsp_valid;
            prev_rr = rsp_ready;
            prev_id = rsp_id;
            prev_p  = rsp_product;
            prev_e  = rsp_err;
        end
    end

    task automatic wait_gnt(input int n);
        int t = 0;
        while (n_gnt < n && t < 300) begin @(posedge clk); t++; end
        #1;
        chk("wait_gnt", n_gnt >= n, 1);
    endtask

    task automatic wait_rsp(input int n);
        int t = 0;
        while (n_rsp < n && t < 300) begin @(posedge clk); t++; end
        #1;
        chk("wait_rsp", n_rsp >= n, 1);
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    initial begin
        int t;
        @(posedge clk); #1;
        set_op(0, 8'd127, -8'sd128);
        set_op(1, -8'sd128, -8'sd128);
        set_op(2, -8'sd1, 8'd1);
        set_op(3, 8'd5, -8'sd3);
        req_valid = 4'b1111;
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_en", mul_en, 0);
        chk("rst_start", mul_start, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_prod", rsp_product, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_mul_ab", {mul_a, mul_b}, 0);
        // All four contending: round robin from requester 0.
        foreach (exp_gnt[i]) exp_gnt.delete(i);
        exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
        exp_gnt.push_back(3); exp_gnt.push_back(0);
        @(posedge clk); #1 rst = 0;
        wait_gnt(5);
        req_valid = 0;
        wait_rsp(5);
        // Single request from requester 2.
        set_op(2, -8'sd7, 8'd12);
        exp_gnt.push_back(2);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("t1_ready", req_ready, 4'b0100);
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk);
        chk("t1_ready_drop", req_ready, 0);
        chk("t1_start", mul_start, 1);
        wait_rsp(6);
        // Back-pressure with another requester waiting.
        set_op(3, 8'd100, -8'sd2);
        exp_gnt.push_back(3);
        rsp_ready = 0;
        req_valid = 4'b1000;
        wait_gnt(7);
        set_op(1, 8'd3, -8'sd4);
        exp_gnt.push_back(1);
        req_valid = 4'b0010;
        t = 0;
        while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
        chk("t3_rsp_seen", rsp_valid, 1);
        repeat (5) begin
            @(negedge clk);
            chk("t3_no_ready", req_ready, 0);
            chk("t3_hold_valid", rsp_valid, 1);
        end
        @(posedge clk); #1 rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("t3_valid_fall", rsp_valid, 0);
        chk("t3_idle_grant", req_ready, 4'b0010);
        @(posedge clk); #1 req_valid = 0;
        wait_rsp(8);
        // Stale done from the previous operation held two cycles past start.
        m_stale = 2;
        set_op(0, 8'd11, 8'd13);
        exp_gnt.push_back(0);
        req_valid = 4'b0001;
        wait_gnt(9);
        req_valid = 0;
        wait_rsp(9);
        m_stale = 0;
        // Multiplier never finishes: timeout error response.
        m_stuck = 1;
        exp_err = 1;
        set_op(2, 8'd9, 8'd9);
        exp_gnt.push_back(2);
        req_valid = 4'b0100;
        wait_gnt(10);
        req_valid = 0;
        exp_err = 0;
        wait_rsp(10);
        m_stuck = 0;
        m_lat = 3;
        set_op(3, -8'sd50, 8'd2);
        exp_gnt.push_back(3);
        req_valid = 4'b1000;
        wait_gnt(11);
        req_valid = 0;
        wait_rsp(11);
        // Reset while waiting on the multiplier.
        m_lat = 10;
        set_op(1, 8'd7, 8'd7);
        exp_gnt.push_back(1);
        req_valid = 4'b0010;
        wait_gnt(12);
        req_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_busy", mul_en, 1);
        rst = 1;
        sb.delete();
        set_op(0, -8'sd3, -8'sd5);
        req_valid = 4'b1001;
        m_lat = 2;
        @(negedge clk);
        chk("t6_rst_en", mul_en, 0);
        chk("t6_rst_ready", req_ready, 0);
        exp_gnt.push_back(0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_rsp_regs", {rsp_id, rsp_product, rsp_err}, 0);
        chk("t6_mul_ab", {mul_a, mul_b}, 0);
        chk("t6_grant0", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid = 0;
        wait_rsp(12);
        repeat (10) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("gnt_total", n_gnt, 13);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
